// File: rtl/operand_issue_pkg.sv
// Shared types and constants for the operand issue stage and its scoreboard.
// Register index is the address taken modulo NUM_REGS (a power of two).
package operand_issue_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 6;
    localparam int CTRL_W   = 16;
    localparam int IDX_W    = $clog2(NUM_REGS);

    typedef logic [31:0]       bus_type;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [IDX_W-1:0]  reg_idx_t;

    typedef struct packed {
        reg_addr_t         rs1;
        reg_addr_t         rs2;
        reg_addr_t         rd;
        logic              rd_we;
        logic [CTRL_W-1:0] ctrl;
    } issue_pkt_t;

    // Hold-register states, derived each cycle from h_valid and move
    localparam logic [1:0] H_EMPTY = 2'd0;
    localparam logic [1:0] H_STALL = 2'd1;
    localparam logic [1:0] H_MOVE  = 2'd2;

    function automatic reg_idx_t reg_idx(input reg_addr_t addr);
        return addr[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/operand_issue_scoreboard.sv
// One pending bit per architectural register; a set in the same cycle as a
// clear of the same register wins, and register 0 can never become pending.
module operand_issue_scoreboard
    import operand_issue_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  reg_addr_t           set_addr,
    input  logic                clr_en,
    input  reg_addr_t           clr_addr,
    output logic [NUM_REGS-1:0] pending
);

    localparam logic [NUM_REGS-1:0] BIT0 = NUM_REGS'(1);

    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^{set_addr[ADDR_W-1:IDX_W], clr_addr[ADDR_W-1:IDX_W]};

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) set_vec[reg_idx(set_addr)] = 1'b1;
        if (clr_en) clr_vec[reg_idx(clr_addr)] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= ((pending & ~clr_vec) | set_vec) & ~BIT0;
    end

endmodule

// File: rtl/operand_issue.sv
// Operand issue stage: hold register, hazard scoreboard and issue slot.
// Define OPERAND_ISSUE_BYPASS_EN to forward writeback data into the issuing instruction.
//
// state   | meaning
// EMPTY   | hold register has no instruction
// STALL   | instruction held, blocked by a hazard or a busy issue slot
// MOVE    | instruction moves into the issue slot this cycle
module operand_issue
    import operand_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  reg_addr_t         in_rs1,
    input  reg_addr_t         in_rs2,
    input  reg_addr_t         in_rd,
    input  logic              in_rd_we,
    input  logic [CTRL_W-1:0] in_ctrl,
    output reg_addr_t         rf_read_addr_1,
    output reg_addr_t         rf_read_addr_2,
    input  bus_type           rf_value_1,
    input  bus_type           rf_value_2,
    input  logic              wb_valid,
    input  reg_addr_t         wb_addr,
    input  bus_type           wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output bus_type           out_op1,
    output bus_type           out_op2,
    output reg_addr_t         out_rd,
    output logic              out_rd_we,
    output logic [CTRL_W-1:0] out_ctrl
);

    issue_pkt_t          in_pkt;
    issue_pkt_t          h_pkt;
    logic                h_valid;
    logic [1:0]          h_state;

    logic                o_valid;
    bus_type             o_op1;
    bus_type             o_op2;
    reg_addr_t           o_rd;
    logic                o_rd_we;
    logic [CTRL_W-1:0]   o_ctrl;

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_eff;
    bus_type             op1_next;
    bus_type             op2_next;
    logic                src1_busy;
    logic                src2_busy;
    logic                dst_busy;
    logic                hazard;
    logic                move;
    logic                accept;
    logic                sb_set;

    assign in_pkt = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, rd_we: in_rd_we, ctrl: in_ctrl};

    assign rf_read_addr_1 = h_valid ? h_pkt.rs1 : '0;
    assign rf_read_addr_2 = h_valid ? h_pkt.rs2 : '0;

`ifdef OPERAND_ISSUE_BYPASS_EN
    // A register written back this cycle counts as ready and its value comes off the bus
    logic [NUM_REGS-1:0] wb_hit;

    always_comb begin
        wb_hit = '0;
        if (wb_valid) wb_hit[reg_idx(wb_addr)] = 1'b1;
    end

    assign pending_eff = pending & ~wb_hit;
    assign op1_next = (wb_hit[reg_idx(h_pkt.rs1)] && pending[reg_idx(h_pkt.rs1)]) ? wb_data : rf_value_1;
    assign op2_next = (wb_hit[reg_idx(h_pkt.rs2)] && pending[reg_idx(h_pkt.rs2)]) ? wb_data : rf_value_2;
`else
    logic unused_wb_data;

    assign unused_wb_data = ^wb_data;
    assign pending_eff    = pending;
    assign op1_next       = rf_value_1;
    assign op2_next       = rf_value_2;
`endif

    assign src1_busy = (reg_idx(h_pkt.rs1) != '0) && pending_eff[reg_idx(h_pkt.rs1)];
    assign src2_busy = (reg_idx(h_pkt.rs2) != '0) && pending_eff[reg_idx(h_pkt.rs2)];
    assign dst_busy  = h_pkt.rd_we && (reg_idx(h_pkt.rd) != '0) && pending_eff[reg_idx(h_pkt.rd)];
    assign hazard    = h_valid && (src1_busy || src2_busy || dst_busy);
    assign move      = h_valid && !hazard && (!o_valid || out_ready);

    always_comb begin
        if (!h_valid)  h_state = H_EMPTY;
        else if (move) h_state = H_MOVE;
        else           h_state = H_STALL;
    end

    assign in_ready = (h_state != H_STALL);
    assign accept   = in_valid && in_ready;
    assign sb_set   = move && h_pkt.rd_we && (reg_idx(h_pkt.rd) != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_valid <= 1'b0;
            h_pkt   <= '0;
        end else if (accept) begin
            h_valid <= 1'b1;
            h_pkt   <= in_pkt;
        end else if (move) begin
            h_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_op1   <= '0;
            o_op2   <= '0;
            o_rd    <= '0;
            o_rd_we <= 1'b0;
            o_ctrl  <= '0;
        end else if (move) begin
            o_valid <= 1'b1;
            o_op1   <= op1_next;
            o_op2   <= op2_next;
            o_rd    <= h_pkt.rd;
            o_rd_we <= h_pkt.rd_we;
            o_ctrl  <= h_pkt.ctrl;
        end else if (out_ready) begin
            o_valid <= 1'b0;
        end
    end

    operand_issue_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set),
        .set_addr (h_pkt.rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .pending  (pending)
    );

    assign out_valid = o_valid;
    assign out_op1   = o_op1;
    assign out_op2   = o_op2;
    assign out_rd    = o_rd;
    assign out_rd_we = o_rd_we;
    assign out_ctrl  = o_ctrl;

endmodule
